dlsc_pcie_s6_inbound_dispatch: RTL and testbench
================================================

// Module: dlsc_pcie_s6_inbound_dispatch
// PURPOSE
//  Sequences parsed inbound request headers (from the inbound TLP decoder) onto separate
//  write-command and read-command channels for the downstream bus master. Enforces PCIe
//  ordering: a read never passes an earlier write; a non-posted (I/O/config) write is fully
//  completed before any later request issues. Caps outstanding writes and reads.
// PARAMETERS
//  ADDR        32  translated address width; address ports are [ADDR-1:2]
//  MAX_WRITES  16  max writes issued but not yet acknowledged (wr_done); power of 2, >=2
//  MAX_READS   4   max reads issued but not yet retired (rd_done); power of 2, >=1
// PORTS
//  clk             in   1       clock
//  rst             in   1       reset, synchronous, active-high
//  tlp_h_ready     out  1       header accept
//  tlp_h_valid     in   1       header valid
//  tlp_h_np        in   1       non-posted (any read, I/O or config write)
//  tlp_h_write     in   1       1=write, 0=read
//  tlp_h_mem       in   1       memory space (0=I/O/config)
//  tlp_h_addr      in   ADDR-2  translated DW address
//  tlp_h_len       in   10      length in DW; 0 encodes 1024
//  tlp_h_be_first  in   4       first-DW byte enables
//  tlp_h_be_last   in   4       last-DW byte enables
//  wr_cmd_ready    in   1       write command accept
//  wr_cmd_valid    out  1       write command valid
//  wr_cmd_addr     out  ADDR-2  \
//  wr_cmd_len      out  11      | len decoded: 1..1024
//  wr_cmd_be_first out  4       |
//  wr_cmd_be_last  out  4       | be_last forced 0 when len==1
//  wr_cmd_np       out  1       / completion required for this write
//  wr_done         in   1       pulse: one write fully committed downstream
//  rd_cmd_ready    in   1       read command accept
//  rd_cmd_valid    out  1       read command valid
//  rd_cmd_addr/len/be_first/be_last/mem  out  as write channel (mem = tlp_h_mem)
//  rd_done         in   1       pulse: one read fully completed (all CplD sent)
//  wr_outstanding  out  log2(MAX_WRITES)+1   current write count
//  rd_outstanding  out  log2(MAX_READS)+1    current read count
//  err             out  1       sticky: wr_done/rd_done seen with count==0
// BEHAVIOUR
//  Reset: tlp_h_ready=0, wr/rd_cmd_valid=0, counts=0, err=0, FSM=ST_IDLE.
//  Header/data payload: only the header is handled here; write data flows separately.
//  FSM (state advances per rules; single registered command slot per channel):
//   ST_IDLE: tlp_h_ready=1. On accept latch fields; write -> ST_WR, read -> ST_RD_WAIT.
//   ST_WR: wait wr_outstanding<MAX_WRITES; assert wr_cmd_valid; on wr_cmd_ready&valid
//     count++ ; np write -> ST_NP_WAIT, else -> ST_IDLE.
//   ST_RD_WAIT: wait wr_outstanding==0 and rd_outstanding<MAX_READS -> ST_RD.
//   ST_RD: rd_cmd_valid=1; on handshake rd count++ -> ST_IDLE.
//   ST_NP_WAIT: wait wr_outstanding==0 -> ST_IDLE.
//  Latency: header accepted cycle N -> cmd_valid earliest N+1 (posted write, no stall).
//   Back-to-back posted writes: one header per 2 cycles min.
//  Valid, once asserted, holds with stable payload until ready (AXI-style rule).
//  Counters: same-cycle issue and done -> count unchanged. done at count 0 -> no
//   underflow, err<=1. Count never exceeds MAX (issue blocked at MAX).
//  Length: wr/rd_cmd_len = (tlp_h_len==0) ? 1024 : tlp_h_len, 11-bit.
//  Zero-length read (len=1, be_first=0) is dispatched normally (still needs completion).
//  Reset mid-operation: all state/counters cleared next cycle; pending commands dropped.
// STRUCTURE
//  Shared package/header: FSM state encodings, len-decode function (0->1024).
//  One sub-module: dlsc_pcie_s6_outstanding_ctr (up/down counter, MAX limit, full/empty,
//  underflow error), instantiated twice (writes, reads).
// TESTING
//  1. Posted write addr=0x1000 len=4 -> wr_cmd_valid at N+1, len=4, np=0; wr_outstanding=1.
//  2. Write then read, wr_done withheld 20 cycles -> rd_cmd_valid stays 0 until cycle
//     after wr_done; rd_outstanding 0->1 on handshake.
//  3. 17 posted writes, no wr_done -> 16 issue, 17th held with wr_cmd_valid=1 stalled in
//     ST_WR? no: held in ST_WR without valid until one wr_done, then issues.
//  4. Config write (np=1) followed by read -> read header not accepted until wr_done.
//  5. len=0 read -> rd_cmd_len=1024; rd_done at rd_outstanding=0 -> err=1, count stays 0.
//  6. rst asserted with rd_cmd_valid stalled -> next cycle valids=0, counts=0, tlp_h_ready=0.

Source files
------------

// File: rtl/dlsc_pcie_s6_inbound_dispatch_pkg.sv
// Shared types and helpers for the inbound request dispatcher: FSM state encoding
// and the PCIe length decode (a length field of 0 means 1024 DW).
package dlsc_pcie_s6_inbound_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD      = 3'd3,
    ST_NP_WAIT = 3'd4
  } dispatch_state_t;

  function automatic logic [10:0] decode_len(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

// File: rtl/dlsc_pcie_s6_outstanding_ctr.sv
// Up/down counter of in-flight requests with a hard ceiling and a sticky underflow flag.
module dlsc_pcie_s6_outstanding_ctr #(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         full_o,
  output logic         err_o
);

  logic [W-1:0] count_q, count_d;
  logic         err_q, err_d;

  assign full_o  = (count_q == W'(MAX));
  assign count_o = count_q;
  assign err_o   = err_q;

  // A simultaneous issue and retire cancel out, even when the count is zero.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (inc_i && !dec_i && !full_o) begin
      count_d = count_q + W'(1);
    end else if (dec_i && !inc_i) begin
      if (count_q == '0) err_d = 1'b1;
      else               count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/dlsc_pcie_s6_inbound_dispatch.sv
// Orders parsed inbound request headers onto write/read command channels: reads wait for
// all earlier writes, non-posted writes drain completely before the next header is taken.
module dlsc_pcie_s6_inbound_dispatch
  import dlsc_pcie_s6_inbound_dispatch_pkg::*;
#(
  parameter int ADDR       = 32,
  parameter int MAX_WRITES = 16,
  parameter int MAX_READS  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         tlp_h_ready,
  input  logic                         tlp_h_valid,
  input  logic                         tlp_h_np,
  input  logic                         tlp_h_write,
  input  logic                         tlp_h_mem,
  input  logic [ADDR-1:2]              tlp_h_addr,
  input  logic [9:0]                   tlp_h_len,
  input  logic [3:0]                   tlp_h_be_first,
  input  logic [3:0]                   tlp_h_be_last,
  input  logic                         wr_cmd_ready,
  output logic                         wr_cmd_valid,
  output logic [ADDR-1:2]              wr_cmd_addr,
  output logic [10:0]                  wr_cmd_len,
  output logic [3:0]                   wr_cmd_be_first,
  output logic [3:0]                   wr_cmd_be_last,
  output logic                         wr_cmd_np,
  input  logic                         wr_done,
  input  logic                         rd_cmd_ready,
  output logic                         rd_cmd_valid,
  output logic [ADDR-1:2]              rd_cmd_addr,
  output logic [10:0]                  rd_cmd_len,
  output logic [3:0]                   rd_cmd_be_first,
  output logic [3:0]                   rd_cmd_be_last,
  output logic                         rd_cmd_mem,
  input  logic                         rd_done,
  output logic [$clog2(MAX_WRITES):0]  wr_outstanding,
  output logic [$clog2(MAX_READS):0]   rd_outstanding,
  output logic                         err,
  output dispatch_state_t              dbg_state
);

  localparam int WW = $clog2(MAX_WRITES) + 1;
  localparam int RW = $clog2(MAX_READS) + 1;

  // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
  // once valid rises it stays high with an unchanged payload until that edge.
  dispatch_state_t state_q, state_d;
  logic            ready_q;
  logic [ADDR-1:2] addr_q;
  logic [10:0]     len_q;
  logic [3:0]      be_first_q, be_last_q;
  logic            np_q, mem_q;
  logic            wr_full, rd_full, wr_empty, wr_issue, rd_issue, wr_err, rd_err;

  assign tlp_h_ready  = ready_q;
  assign dbg_state    = state_q;
  assign wr_empty     = (wr_outstanding == '0);
  assign wr_cmd_valid = (state_q == ST_WR) && !wr_full;
  assign rd_cmd_valid = (state_q == ST_RD);
  assign wr_issue     = wr_cmd_valid && wr_cmd_ready;
  assign rd_issue     = rd_cmd_valid && rd_cmd_ready;
  assign err          = wr_err | rd_err;

  assign wr_cmd_addr     = addr_q;
  assign wr_cmd_len      = len_q;
  assign wr_cmd_be_first = be_first_q;
  assign wr_cmd_be_last  = be_last_q;
  assign wr_cmd_np       = np_q;
  assign rd_cmd_addr     = addr_q;
  assign rd_cmd_len      = len_q;
  assign rd_cmd_be_first = be_first_q;
  assign rd_cmd_be_last  = be_last_q;
  assign rd_cmd_mem      = mem_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (tlp_h_valid && tlp_h_ready) state_d = tlp_h_write ? ST_WR : ST_RD_WAIT;
      ST_WR:      if (wr_issue) state_d = np_q ? ST_NP_WAIT : ST_IDLE;
      ST_RD_WAIT: if (wr_empty && !rd_full) state_d = ST_RD;
      ST_RD:      if (rd_issue) state_d = ST_IDLE;
      ST_NP_WAIT: if (wr_empty) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Header ready is registered so it stays low for the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      be_first_q <= '0;
      be_last_q  <= '0;
      np_q       <= 1'b0;
      mem_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      if (state_q == ST_IDLE && tlp_h_valid && tlp_h_ready) begin
        addr_q     <= tlp_h_addr;
        len_q      <= decode_len(tlp_h_len);
        be_first_q <= tlp_h_be_first;
        be_last_q  <= (tlp_h_len == 10'd1) ? 4'h0 : tlp_h_be_last;
        np_q       <= tlp_h_np;
        mem_q      <= tlp_h_mem;
      end
    end
  end

  dlsc_pcie_s6_outstanding_ctr #(.MAX(MAX_WRITES), .W(WW)) u_wr_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (wr_issue),
    .dec_i   (wr_done),
    .count_o (wr_outstanding),
    .full_o  (wr_full),
    .err_o   (wr_err)
  );

  dlsc_pcie_s6_outstanding_ctr #(.MAX(MAX_READS), .W(RW)) u_rd_ctr (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (rd_issue),
    .dec_i   (rd_done),
    .count_o (rd_outstanding),
    .full_o  (rd_full),
    .err_o   (rd_err)
  );

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_dispatch.sv
// Self-checking bench for the inbound dispatcher: directed scenarios plus a randomized
// mix, with an in-order command scoreboard and outstanding-count model.
module tb_dlsc_pcie_s6_inbound_dispatch;
  import dlsc_pcie_s6_inbound_dispatch_pkg::*;

  localparam int EW = 1 + 30 + 11 + 4 + 4 + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tlp_h_ready;
  logic        tlp_h_valid = 1'b0, tlp_h_np = 1'b0, tlp_h_write = 1'b0, tlp_h_mem = 1'b0;
  logic [31:2] tlp_h_addr = '0;
  logic [9:0]  tlp_h_len = '0;
  logic [3:0]  tlp_h_be_first = '0, tlp_h_be_last = '0;
  logic        wr_cmd_ready = 1'b0, wr_cmd_valid, wr_cmd_np, wr_done = 1'b0;
  logic [31:2] wr_cmd_addr, rd_cmd_addr;
  logic [10:0] wr_cmd_len, rd_cmd_len;
  logic [3:0]  wr_cmd_be_first, wr_cmd_be_last, rd_cmd_be_first, rd_cmd_be_last;
  logic        rd_cmd_ready = 1'b0, rd_cmd_valid, rd_cmd_mem, rd_done = 1'b0;
  logic [4:0]  wr_outstanding;
  logic [2:0]  rd_outstanding;
  logic        err;
  dispatch_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int model_wr = 0, model_rd = 0;
  bit model_err = 0, np_block = 0;
  bit prev_wr_hold = 0, prev_rd_hold = 0;
  logic [EW-1:0] prev_wr_pl, prev_rd_pl, wr_obs, rd_obs, exp_v;
  bit wr_hs, rd_hs, stop_rand, drv_done;

  dlsc_pcie_s6_inbound_dispatch dut (
    .clk(clk), .rst(rst),
    .tlp_h_ready(tlp_h_ready), .tlp_h_valid(tlp_h_valid), .tlp_h_np(tlp_h_np),
    .tlp_h_write(tlp_h_write), .tlp_h_mem(tlp_h_mem), .tlp_h_addr(tlp_h_addr),
    .tlp_h_len(tlp_h_len), .tlp_h_be_first(tlp_h_be_first), .tlp_h_be_last(tlp_h_be_last),
    .wr_cmd_ready(wr_cmd_ready), .wr_cmd_valid(wr_cmd_valid), .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_len(wr_cmd_len), .wr_cmd_be_first(wr_cmd_be_first),
    .wr_cmd_be_last(wr_cmd_be_last), .wr_cmd_np(wr_cmd_np), .wr_done(wr_done),
    .rd_cmd_ready(rd_cmd_ready), .rd_cmd_valid(rd_cmd_valid), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_len(rd_cmd_len), .rd_cmd_be_first(rd_cmd_be_first),
    .rd_cmd_be_last(rd_cmd_be_last), .rd_cmd_mem(rd_cmd_mem), .rd_done(rd_done),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign wr_obs = {1'b1, wr_cmd_addr, wr_cmd_len, wr_cmd_be_first, wr_cmd_be_last, wr_cmd_np};
  assign rd_obs = {1'b0, rd_cmd_addr, rd_cmd_len, rd_cmd_be_first, rd_cmd_be_last, rd_cmd_mem};

  // Expected command for a header: length 0 means 1024 DW, single-DW has no last BE.
  function automatic logic [EW-1:0] exp_cmd(bit w, logic [29:0] a, logic [9:0] l,
                                            logic [3:0] bf, logic [3:0] bl, bit flag);
    int n;
    n = (l == 0) ? 1024 : int'(l);
    return {w, a, 11'(n), bf, (n == 1) ? 4'h0 : bl, flag};
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_wr = 0; model_rd = 0; model_err = 0; np_block = 0;
      prev_wr_hold = 0; prev_rd_hold = 0;
    end else begin
      wr_hs = wr_cmd_valid && wr_cmd_ready;
      rd_hs = rd_cmd_valid && rd_cmd_ready;
      checks++;
      if (wr_outstanding !== 5'(model_wr)) begin
        errors++; $display("FAIL wr_outstanding: got %0d expected %0d", wr_outstanding, model_wr);
      end
      checks++;
      if (rd_outstanding !== 3'(model_rd)) begin
        errors++; $display("FAIL rd_outstanding: got %0d expected %0d", rd_outstanding, model_rd);
      end
      checks++;
      if (err !== model_err) begin
        errors++; $display("FAIL err: got %0b expected %0b", err, model_err);
      end
      if (tlp_h_valid && tlp_h_ready) begin
        checks++;
        if (np_block) begin
          errors++; $display("FAIL np_order: header accepted with %0d writes pending", model_wr);
        end
      end
      if (prev_wr_hold) begin
        checks++;
        if (!wr_cmd_valid || wr_obs !== prev_wr_pl) begin
          errors++; $display("FAIL wr_hold: got v=%0b %h expected v=1 %h", wr_cmd_valid, wr_obs, prev_wr_pl);
        end
      end
      if (prev_rd_hold) begin
        checks++;
        if (!rd_cmd_valid || rd_obs !== prev_rd_pl) begin
          errors++; $display("FAIL rd_hold: got v=%0b %h expected v=1 %h", rd_cmd_valid, rd_obs, prev_rd_pl);
        end
      end
      if (wr_cmd_valid) begin
        checks++;
        if (model_wr >= 16) begin
          errors++; $display("FAIL wr_cap: valid with %0d outstanding, limit 16", model_wr);
        end
      end
      if (rd_cmd_valid) begin
        checks++;
        if (model_wr != 0 || model_rd >= 4) begin
          errors++; $display("FAIL rd_order: valid with wr=%0d rd=%0d, expected wr=0 rd<4", model_wr, model_rd);
        end
      end
      if (wr_hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL wr_cmd: got %h expected no command", wr_obs);
        end else begin
          exp_v = exp_q.pop_front();
          if (wr_obs !== exp_v) begin
            errors++; $display("FAIL wr_cmd: got %h expected %h", wr_obs, exp_v);
          end
        end
      end
      if (rd_hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rd_cmd: got %h expected no command", rd_obs);
        end else begin
          exp_v = exp_q.pop_front();
          if (rd_obs !== exp_v) begin
            errors++; $display("FAIL rd_cmd: got %h expected %h", rd_obs, exp_v);
          end
        end
      end
      if (wr_hs && !wr_done) model_wr++;
      else if (!wr_hs && wr_done) begin
        if (model_wr == 0) model_err = 1; else model_wr--;
      end
      if (rd_hs && !rd_done) model_rd++;
      else if (!rd_hs && rd_done) begin
        if (model_rd == 0) model_err = 1; else model_rd--;
      end
      if (wr_hs && wr_cmd_np) np_block = 1;
      else if (model_wr == 0) np_block = 0;
      prev_wr_hold = wr_cmd_valid && !wr_cmd_ready;
      prev_rd_hold = rd_cmd_valid && !rd_cmd_ready;
      prev_wr_pl = wr_obs;
      prev_rd_pl = rd_obs;
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive_hdr(bit w, bit np, bit mem, logic [29:0] a, logic [9:0] l,
                           logic [3:0] bf, logic [3:0] bl);
    tlp_h_write = w; tlp_h_np = np; tlp_h_mem = mem; tlp_h_addr = a;
    tlp_h_len = l; tlp_h_be_first = bf; tlp_h_be_last = bl; tlp_h_valid = 1'b1;
  endtask

  task automatic wait_accept;
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tlp_h_ready) begin
        exp_q.push_back(exp_cmd(tlp_h_write, tlp_h_addr, tlp_h_len, tlp_h_be_first,
                                tlp_h_be_last, tlp_h_write ? tlp_h_np : tlp_h_mem));
        ok = 1;
        break;
      end
      tick();
    end
    if (ok) tick();
    tlp_h_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL hdr_accept: got no accept expected accept within 2000 cycles");
    end
  endtask

  task automatic send_hdr(bit w, bit np, bit mem, logic [29:0] a, logic [9:0] l,
                          logic [3:0] bf, logic [3:0] bl);
    drive_hdr(w, np, mem, a, l, bf, bl);
    wait_accept();
  endtask

  task automatic pulse_wr_done;
    wr_done = 1'b1; tick(); wr_done = 1'b0;
  endtask

  task automatic pulse_rd_done;
    rd_done = 1'b1; tick(); rd_done = 1'b0;
  endtask

  task automatic wait_rd_count(int n, string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_outstanding == 3'(n)) begin ok = 1; break; end
      tick();
    end
    tick();
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s: got rd_outstanding %0d expected %0d", name, rd_outstanding, n);
    end
  endtask

  task automatic wait_rd_valid(string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_cmd_valid) begin ok = 1; break; end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s: got rd_cmd_valid 0 expected 1", name);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({tlp_h_ready, wr_cmd_valid, rd_cmd_valid, err} !== 4'b0 ||
        wr_outstanding !== 5'd0 || rd_outstanding !== 3'd0) begin
      errors++; $display("FAIL reset_state: got rdy=%0b wv=%0b rv=%0b err=%0b wo=%0d ro=%0d expected all 0",
        tlp_h_ready, wr_cmd_valid, rd_cmd_valid, err, wr_outstanding, rd_outstanding);
    end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (tlp_h_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %0b expected 1", tlp_h_ready);
    end
    tick();
  endtask

  task automatic test_posted_write;
    wr_cmd_ready = 1'b0;
    send_hdr(1, 0, 1, 30'h400, 10'd4, 4'hF, 4'hF);
    @(negedge clk);
    checks++;
    if (wr_cmd_valid !== 1'b1 || wr_cmd_len !== 11'd4 || wr_cmd_np !== 1'b0 || wr_cmd_addr !== 30'h400) begin
      errors++; $display("FAIL posted_latency: got v=%0b len=%0d np=%0b addr=%h expected v=1 len=4 np=0 addr=400",
        wr_cmd_valid, wr_cmd_len, wr_cmd_np, wr_cmd_addr);
    end
    tick();
    wr_cmd_ready = 1'b1;
    tick();
    wr_cmd_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_outstanding !== 5'd1) begin
      errors++; $display("FAIL posted_count: got %0d expected 1", wr_outstanding);
    end
    tick();
    pulse_wr_done();
  endtask

  task automatic test_write_then_read;
    wr_cmd_ready = 1'b1; rd_cmd_ready = 1'b1;
    send_hdr(1, 0, 1, 30'h800, 10'd2, 4'hF, 4'h3);
    send_hdr(0, 1, 1, 30'h900, 10'd1, 4'hF, 4'hF);
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (rd_cmd_valid !== 1'b0 || rd_outstanding !== 3'd0) begin
        errors++; $display("FAIL rd_blocked: got v=%0b ro=%0d expected v=0 ro=0", rd_cmd_valid, rd_outstanding);
      end
      tick();
    end
    pulse_wr_done();
    wait_rd_count(1, "rd_after_wr_done");
    pulse_rd_done();
  endtask

  task automatic test_write_cap;
    wr_cmd_ready = 1'b1;
    for (int i = 0; i < 17; i++)
      send_hdr(1, 0, 1, 30'(i * 16), 10'($urandom_range(1, 8)), 4'hF, 4'hF);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (wr_cmd_valid !== 1'b0 || wr_outstanding !== 5'd16) begin
        errors++; $display("FAIL wr_cap_hold: got v=%0b wo=%0d expected v=0 wo=16", wr_cmd_valid, wr_outstanding);
      end
      tick();
    end
    pulse_wr_done();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wr_cap_release: got %0d pending expected 0", exp_q.size());
    end
    repeat (16) pulse_wr_done();
    @(negedge clk);
    checks++;
    if (wr_outstanding !== 5'd0) begin
      errors++; $display("FAIL wr_cap_drain: got %0d expected 0", wr_outstanding);
    end
    tick();
  endtask

  task automatic test_np_write;
    wr_cmd_ready = 1'b1; rd_cmd_ready = 1'b1;
    send_hdr(1, 1, 0, 30'h10, 10'd1, 4'hF, 4'hF);
    drive_hdr(0, 1, 0, 30'h20, 10'd1, 4'hF, 4'h0);
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (tlp_h_ready !== 1'b0) begin
        errors++; $display("FAIL np_block: got ready %0b expected 0", tlp_h_ready);
      end
      tick();
    end
    pulse_wr_done();
    wait_accept();
    wait_rd_count(1, "np_read_issue");
    pulse_rd_done();
  endtask

  task automatic test_len0_read_underflow;
    pulse_rd_done();
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || rd_outstanding !== 3'd0) begin
      errors++; $display("FAIL underflow: got err=%0b ro=%0d expected err=1 ro=0", err, rd_outstanding);
    end
    tick();
    rd_cmd_ready = 1'b0;
    send_hdr(0, 1, 1, 30'h2000, 10'd0, 4'hF, 4'h3);
    wait_rd_valid("len0_valid");
    checks++;
    if (rd_cmd_len !== 11'd1024 || rd_cmd_be_last !== 4'h3 || rd_cmd_mem !== 1'b1) begin
      errors++; $display("FAIL len0: got len=%0d bel=%h mem=%0b expected len=1024 bel=3 mem=1",
        rd_cmd_len, rd_cmd_be_last, rd_cmd_mem);
    end
    tick(); rd_cmd_ready = 1'b1; tick(); rd_cmd_ready = 1'b0;
    pulse_rd_done();
    send_hdr(0, 1, 1, 30'h3000, 10'd1, 4'h0, 4'hF);
    wait_rd_valid("zero_len_valid");
    checks++;
    if (rd_cmd_len !== 11'd1 || rd_cmd_be_first !== 4'h0 || rd_cmd_be_last !== 4'h0) begin
      errors++; $display("FAIL zero_len: got len=%0d bef=%h bel=%h expected len=1 bef=0 bel=0",
        rd_cmd_len, rd_cmd_be_first, rd_cmd_be_last);
    end
    tick(); rd_cmd_ready = 1'b1; tick(); rd_cmd_ready = 1'b0;
    pulse_rd_done();
  endtask

  task automatic test_reset_midop;
    rd_cmd_ready = 1'b1;
    send_hdr(0, 1, 1, 30'h40, 10'd8, 4'hF, 4'hF);
    wait_rd_count(1, "midop_first_read");
    rd_cmd_ready = 1'b0;
    send_hdr(0, 1, 1, 30'h50, 10'd2, 4'hF, 4'hF);
    wait_rd_valid("midop_stall");
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({tlp_h_ready, wr_cmd_valid, rd_cmd_valid, err} !== 4'b0 ||
        wr_outstanding !== 5'd0 || rd_outstanding !== 3'd0) begin
      errors++; $display("FAIL reset_midop: got rdy=%0b wv=%0b rv=%0b err=%0b wo=%0d ro=%0d expected all 0",
        tlp_h_ready, wr_cmd_valid, rd_cmd_valid, err, wr_outstanding, rd_outstanding);
    end
    tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random;
    int cyc;
    stop_rand = 0; drv_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          bit w, np, mem;
          logic [9:0] l;
          w   = ($urandom_range(0, 2) != 0);
          np  = w ? ($urandom_range(0, 5) == 0) : 1'b1;
          mem = w ? !np : 1'($urandom_range(0, 1));
          l   = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
          send_hdr(w, np, mem, 30'($urandom), l, 4'($urandom), 4'($urandom));
          repeat ($urandom_range(0, 2)) tick();
        end
        drv_done = 1;
      end
      begin
        while (!stop_rand) begin
          wr_cmd_ready = ($urandom_range(0, 3) != 0);
          rd_cmd_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
      begin
        while (!stop_rand) begin
          wr_done = (model_wr > 0) && ($urandom_range(0, 2) == 0);
          rd_done = (model_rd > 0) && ($urandom_range(0, 1) == 0);
          tick();
        end
        wr_done = 1'b0; rd_done = 1'b0;
      end
      begin
        cyc = 0;
        while (!(drv_done && exp_q.size() == 0 && model_wr == 0 && model_rd == 0) && cyc < 20000) begin
          tick();
          cyc++;
        end
        checks++;
        if (cyc >= 20000) begin
          errors++; $display("FAIL random_drain: got %0d pending expected 0 within 20000 cycles", exp_q.size());
        end
        stop_rand = 1;
      end
    join
    wr_cmd_ready = 1'b0; rd_cmd_ready = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_posted_write();
    test_write_then_read();
    test_write_cap();
    test_np_write();
    test_random();
    test_len0_read_underflow();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
